nec_ir_cmd_ctrl: RTL and testbench

//  Sequencer between the NEC IR receiver datapath and the Wishbone/firmware side of the user project.
//  - Arms the receiver and accepts raw 32-bit NEC frames.
//  - Checks byte complements, handles NEC repeat codes, buffers commands {addr,data} in a small FIFO.
//  - Raises a level IRQ while commands are pending.

---
 rtl/nec_ir_pkg.sv | 31 +++
 rtl/nec_cmd_fifo.sv | 69 ++++++
 rtl/nec_ir_cmd_ctrl.sv | 177 +++++++++++++++++
 tb/tb_nec_ir_cmd_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nec_ir_pkg.sv
// Shared definitions for the NEC IR command controller: FSM encoding, frame field
// offsets, command width and frame decode helpers.
package nec_ir_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_CHECK = 2'd2,
      ST_PUSH  = 2'd3
   } nec_state_e;

   localparam int ADDR_LSB  = 0;
   localparam int ADDRN_LSB = 8;
   localparam int DATA_LSB  = 16;
   localparam int DATAN_LSB = 24;
   localparam int CMD_W     = 16;

   // Extended NEC only guarantees the data byte complement; strict mode also checks the address.
   function automatic logic frame_ok(input logic [31:0] f, input logic strict);
      logic data_ok;
      logic addr_ok;
      data_ok = (f[DATA_LSB +: 8] == ~f[DATAN_LSB +: 8]);
      addr_ok = (f[ADDR_LSB +: 8] == ~f[ADDRN_LSB +: 8]);
      return data_ok && (!strict || addr_ok);
   endfunction

   function automatic logic [CMD_W-1:0] frame_cmd(input logic [31:0] f);
      return {f[ADDR_LSB +: 8], f[DATA_LSB +: 8]};
   endfunction

endpackage

// File: rtl/nec_cmd_fifo.sv
// First-word-fall-through command FIFO; rd_data reads 0 while empty.
// A write while full is accepted only when a read happens in the same cycle.
module nec_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [W-1:0]             wr_data,
   input  logic                     rd_en,
   output logic [W-1:0]             rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             wr_ok, rd_ok;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      full     = (count_q == DEPTH_C);
      empty    = (count_q == '0);
      rd_ok    = rd_en && !empty;
      wr_ok    = wr_en && (!full || rd_ok);
      if (wr_ok) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      rd_data = empty ? '0 : mem_q[rd_ptr_q];
      count   = count_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/nec_ir_cmd_ctrl.sv
// NEC IR command sequencer: arms the receiver, validates frames, queues {addr,data} commands.
// Optional NEC_IR_REPEAT_EN turns repeat codes into re-pushes of the last command within a timeout.
module nec_ir_cmd_ctrl
   import nec_ir_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int REPEAT_TIMEOUT = 4400000,
   parameter int ERR_W          = 8
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_i,
   input  logic                          cfg_en,
   input  logic                          cfg_strict,
   input  logic                          ovf_clr,
   output logic                          rcv_en,
   input  logic                          rx_valid,
   output logic                          rx_ready,
   input  logic                          rx_repeat,
   input  logic [31:0]                   rx_frame,
   input  logic                          pop_req,
   output logic [CMD_W-1:0]              pop_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          irq,
   output logic                          ovf,
   output logic [ERR_W-1:0]              err_cnt,
   output logic [1:0]                    dbg_state
);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of 2 and at least 2");
   end
   if (REPEAT_TIMEOUT < 1) begin : g_bad_timeout
      $error("REPEAT_TIMEOUT must be at least 1");
   end

   nec_state_e       state_q, state_d;
   logic [31:0]      frame_q, frame_d;
   logic [CMD_W-1:0] cmd_q, cmd_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             ovf_q, ovf_d;
   logic             accept, push;
   logic             fifo_full, fifo_empty;

`ifdef NEC_IR_REPEAT_EN
   localparam int TMR_W = $clog2(REPEAT_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(REPEAT_TIMEOUT - 1);

   logic [TMR_W-1:0] timer_q, timer_d;
   logic [CMD_W-1:0] last_cmd_q, last_cmd_d;
   logic             last_valid_q, last_valid_d;
`endif

   // rx_valid&rx_ready completes a handshake; the receiver holds the frame until then.
   always_comb begin
      state_d  = state_q;
      frame_d  = frame_q;
      cmd_d    = cmd_q;
      err_d    = err_q;
      push     = 1'b0;
      rcv_en   = (state_q != ST_IDLE);
      rx_ready = (state_q == ST_ARMED);
      accept   = rx_valid && rx_ready;
      if (!cfg_en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_ARMED;
            ST_ARMED: begin
               if (accept) begin
                  if (!rx_repeat) begin
                     frame_d = rx_frame;
                     state_d = ST_CHECK;
                  end
`ifdef NEC_IR_REPEAT_EN
                  else if (last_valid_q) begin
                     cmd_d   = last_cmd_q;
                     state_d = ST_PUSH;
                  end
`endif
               end
            end
            ST_CHECK: begin
               if (frame_ok(frame_q, cfg_strict)) begin
                  cmd_d   = frame_cmd(frame_q);
                  state_d = ST_PUSH;
               end else begin
                  if (err_q != '1) begin
                     err_d = err_q + 1'b1;
                  end
                  state_d = ST_ARMED;
               end
            end
            ST_PUSH: begin
               push    = 1'b1;
               state_d = ST_ARMED;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      // A new overflow outranks a same-cycle clear.
      if (push && fifo_full && !pop_req) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

`ifdef NEC_IR_REPEAT_EN
   always_comb begin
      timer_d      = timer_q;
      last_cmd_d   = last_cmd_q;
      last_valid_d = last_valid_q;
      if (push) begin
         last_cmd_d   = cmd_q;
         last_valid_d = 1'b1;
         timer_d      = TMR_RELOAD;
      end else if (timer_q != '0) begin
         timer_d = timer_q - 1'b1;
         if (timer_q == TMR_W'(1)) begin
            last_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         timer_q      <= '0;
         last_cmd_q   <= '0;
         last_valid_q <= 1'b0;
      end else begin
         timer_q      <= timer_d;
         last_cmd_q   <= last_cmd_d;
         last_valid_q <= last_valid_d;
      end
   end
`else
`endif

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         frame_q <= '0;
         cmd_q   <= '0;
         err_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         cmd_q   <= cmd_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
      end
   end

   nec_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (CMD_W)
   ) u_fifo (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .wr_en   (push),
      .wr_data (cmd_q),
      .rd_en   (pop_req),
      .rd_data (pop_data),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign irq       = !fifo_empty;
   assign ovf       = ovf_q;
   assign err_cnt   = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_nec_ir_cmd_ctrl.sv
// Directed bench for nec_ir_cmd_ctrl (FIFO_DEPTH=4, REPEAT_TIMEOUT=100); expectations
// for repeat codes follow NEC_IR_REPEAT_EN when it is defined for the build.
module tb_nec_ir_cmd_ctrl;

   localparam int FIFO_DEPTH     = 4;
   localparam int REPEAT_TIMEOUT = 100;
   localparam int ERR_W          = 8;

   logic        clk = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        cfg_en = 1'b0;
   logic        cfg_strict = 1'b1;
   logic        ovf_clr = 1'b0;
   logic        rcv_en;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        rx_repeat = 1'b0;
   logic [31:0] rx_frame = '0;
   logic        pop_req = 1'b0;
   logic [15:0] pop_data;
   logic [2:0]  fifo_count;
   logic        irq;
   logic        ovf;
   logic [7:0]  err_cnt;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   nec_ir_cmd_ctrl #(
      .FIFO_DEPTH     (FIFO_DEPTH),
      .REPEAT_TIMEOUT (REPEAT_TIMEOUT),
      .ERR_W          (ERR_W)
   ) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (wb_rst_i),
      .cfg_en     (cfg_en),
      .cfg_strict (cfg_strict),
      .ovf_clr    (ovf_clr),
      .rcv_en     (rcv_en),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .rx_repeat  (rx_repeat),
      .rx_frame   (rx_frame),
      .pop_req    (pop_req),
      .pop_data   (pop_data),
      .fifo_count (fifo_count),
      .irq        (irq),
      .ovf        (ovf),
      .err_cnt    (err_cnt),
      .dbg_state  (dbg_state)
   );

   function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] d);
      return {~d, d, ~a, a};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns 1ns after the accepting clock edge.
   task automatic send(input logic [31:0] f, input logic rep);
      int waited;
      waited    = 0;
      rx_frame  = f;
      rx_repeat = rep;
      rx_valid  = 1'b1;
      while (!rx_ready && waited < 50) begin
         tick(1);
         waited++;
      end
      if (!rx_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout rx_ready=%0b required=1", rx_ready);
      end
      tick(1);
      rx_valid  = 1'b0;
      rx_repeat = 1'b0;
   endtask

   task automatic pop_one();
      pop_req = 1'b1;
      tick(1);
      pop_req = 1'b0;
   endtask

   task automatic do_reset();
      wb_rst_i   = 1'b1;
      cfg_en     = 1'b0;
      cfg_strict = 1'b1;
      ovf_clr    = 1'b0;
      pop_req    = 1'b0;
      rx_valid   = 1'b0;
      tick(2);
      wb_rst_i = 1'b0;
      cfg_en   = 1'b1;
      tick(1);
   endtask

   task automatic test_reset();
      wb_rst_i = 1'b1;
      cfg_en   = 1'b1;
      tick(3);
      total++;
      if ({rcv_en, rx_ready, irq, ovf, fifo_count, pop_data, err_cnt, dbg_state} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got=%h exp=0",
                  {rcv_en, rx_ready, irq, ovf, fifo_count, pop_data, err_cnt, dbg_state});
      end
      wb_rst_i = 1'b0;
      tick(1);
      total++;
      if ({rcv_en, rx_ready} !== 2'b11) begin
         bad++;
         $display("FAIL reset_armed got=%b exp=11", {rcv_en, rx_ready});
      end
   endtask

   task automatic test_basic();
      do_reset();
      send(32'hB748_C03F, 1'b0);
      total++;
      if (rx_ready !== 1'b0) begin
         bad++;
         $display("FAIL basic_ready_in_check got=%b exp=0", rx_ready);
      end
      tick(1);
      total++;
      if (fifo_count !== 3'd0) begin
         bad++;
         $display("FAIL basic_early_count got=%0d exp=0", fifo_count);
      end
      tick(1);
      total++;
      if ({fifo_count, irq, pop_data} !== {3'd1, 1'b1, 16'h3F48}) begin
         bad++;
         $display("FAIL basic_push count=%0d irq=%b data=%h exp 1 1 3f48", fifo_count, irq, pop_data);
      end
      pop_one();
      total++;
      if ({fifo_count, irq, pop_data} !== {3'd0, 1'b0, 16'h0000}) begin
         bad++;
         $display("FAIL basic_pop count=%0d irq=%b data=%h exp 0 0 0000", fifo_count, irq, pop_data);
      end
   endtask

   task automatic test_integrity();
      do_reset();
      send(32'hB749_C03F, 1'b0);
      tick(1);
      total++;
      if (err_cnt !== 8'd1) begin
         bad++;
         $display("FAIL bad_data_err got=%0d exp=1", err_cnt);
      end
      tick(2);
      total++;
      if (fifo_count !== 3'd0) begin
         bad++;
         $display("FAIL bad_data_nopush got=%0d exp=0", fifo_count);
      end
      cfg_strict = 1'b0;
      send(32'h4DB2_12AB, 1'b0);
      tick(2);
      total++;
      if ({fifo_count, pop_data, err_cnt} !== {3'd1, 16'hABB2, 8'd1}) begin
         bad++;
         $display("FAIL extended_push count=%0d data=%h err=%0d exp 1 abb2 1", fifo_count, pop_data, err_cnt);
      end
      pop_one();
      cfg_strict = 1'b1;
      send(32'h4DB2_12AB, 1'b0);
      tick(2);
      total++;
      if ({fifo_count, err_cnt} !== {3'd0, 8'd2}) begin
         bad++;
         $display("FAIL strict_reject count=%0d err=%0d exp 0 2", fifo_count, err_cnt);
      end
   endtask

   task automatic test_overflow();
      logic [15:0] exp_q[$];
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send(mk(8'(i + 1), 8'(8'h30 + i)), 1'b0);
         tick(2);
         if (i == 3) begin
            total++;
            if ({fifo_count, ovf} !== {3'd4, 1'b0}) begin
               bad++;
               $display("FAIL fill_four count=%0d ovf=%b exp 4 0", fifo_count, ovf);
            end
         end
      end
      total++;
      if ({fifo_count, ovf, pop_data} !== {3'd4, 1'b1, 16'h0130}) begin
         bad++;
         $display("FAIL overflow count=%0d ovf=%b head=%h exp 4 1 0130", fifo_count, ovf, pop_data);
      end
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      total++;
      if (ovf !== 1'b0) begin
         bad++;
         $display("FAIL ovf_clr got=%b exp=0", ovf);
      end
      send(mk(8'h06, 8'h35), 1'b0);
      tick(1);
      pop_one();
      total++;
      if ({fifo_count, ovf, pop_data} !== {3'd4, 1'b0, 16'h0231}) begin
         bad++;
         $display("FAIL pop_push_full count=%0d ovf=%b head=%h exp 4 0 0231", fifo_count, ovf, pop_data);
      end
      send(mk(8'h07, 8'h36), 1'b0);
      tick(1);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      total++;
      if ({fifo_count, ovf} !== {3'd4, 1'b1}) begin
         bad++;
         $display("FAIL ovf_set_wins count=%0d ovf=%b exp 4 1", fifo_count, ovf);
      end
      exp_q = {16'h0231, 16'h0332, 16'h0433, 16'h0635};
      while (exp_q.size() != 0) begin
         total++;
         if (pop_data !== exp_q[0]) begin
            bad++;
            $display("FAIL drain_order got=%h exp=%h", pop_data, exp_q[0]);
         end
         void'(exp_q.pop_front());
         pop_one();
      end
      total++;
      if ({fifo_count, irq} !== {3'd0, 1'b0}) begin
         bad++;
         $display("FAIL drain_empty count=%0d irq=%b exp 0 0", fifo_count, irq);
      end
   endtask

   task automatic test_repeat();
      do_reset();
      send(mk(8'h10, 8'h20), 1'b0);
      tick(2);
      tick(48);
      send(32'h0, 1'b1);
`ifdef NEC_IR_REPEAT_EN
      total++;
      if (rx_ready !== 1'b0) begin
         bad++;
         $display("FAIL repeat_to_push rx_ready=%b exp=0", rx_ready);
      end
      tick(2);
      total++;
      if ({fifo_count, pop_data} !== {3'd2, 16'h1020}) begin
         bad++;
         $display("FAIL repeat_fresh count=%0d head=%h exp 2 1020", fifo_count, pop_data);
      end
      pop_one();
      total++;
      if (pop_data !== 16'h1020) begin
         bad++;
         $display("FAIL repeat_second got=%h exp=1020", pop_data);
      end
      pop_one();
`else
      total++;
      if (rx_ready !== 1'b1) begin
         bad++;
         $display("FAIL repeat_dropped_ready rx_ready=%b exp=1", rx_ready);
      end
      tick(2);
      total++;
      if (fifo_count !== 3'd1) begin
         bad++;
         $display("FAIL repeat_dropped count=%0d exp=1", fifo_count);
      end
      pop_one();
`endif
      tick(150);
      send(32'h0, 1'b1);
      total++;
      if (rx_ready !== 1'b1) begin
         bad++;
         $display("FAIL stale_repeat_ready rx_ready=%b exp=1", rx_ready);
      end
      tick(2);
      total++;
      if ({fifo_count, err_cnt} !== {3'd0, 8'd0}) begin
         bad++;
         $display("FAIL stale_repeat count=%0d err=%0d exp 0 0", fifo_count, err_cnt);
      end
   endtask

   task automatic test_disable_and_reset();
      do_reset();
      send(mk(8'h11, 8'h22), 1'b0);
      cfg_en = 1'b0;
      tick(1);
      total++;
      if ({rcv_en, rx_ready, dbg_state} !== 4'b0000) begin
         bad++;
         $display("FAIL disable_idle rcv_en=%b rx_ready=%b state=%0d exp 0 0 0", rcv_en, rx_ready, dbg_state);
      end
      tick(3);
      total++;
      if (fifo_count !== 3'd0) begin
         bad++;
         $display("FAIL disable_nopush count=%0d exp=0", fifo_count);
      end
      cfg_en = 1'b1;
      tick(1);
      send(32'hB749_C03F, 1'b0);
      tick(1);
      send(mk(8'h12, 8'h34), 1'b0);
      tick(2);
      total++;
      if ({fifo_count, err_cnt} !== {3'd1, 8'd1}) begin
         bad++;
         $display("FAIL pre_reset count=%0d err=%0d exp 1 1", fifo_count, err_cnt);
      end
      send(mk(8'h13, 8'h35), 1'b0);
      tick(1);
      wb_rst_i = 1'b1;
      tick(1);
      total++;
      if ({rcv_en, rx_ready, irq, ovf, fifo_count, pop_data, err_cnt, dbg_state} !== '0) begin
         bad++;
         $display("FAIL reset_mid_push got=%h exp=0",
                  {rcv_en, rx_ready, irq, ovf, fifo_count, pop_data, err_cnt, dbg_state});
      end
      wb_rst_i = 1'b0;
      tick(1);
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         send(32'hB749_C03F, 1'b0);
         tick(1);
         if (i == 253) begin
            total++;
            if (err_cnt !== 8'd254) begin
               bad++;
               $display("FAIL err_254 got=%0d exp=254", err_cnt);
            end
         end
         if (i == 254) begin
            total++;
            if (err_cnt !== 8'd255) begin
               bad++;
               $display("FAIL err_255 got=%0d exp=255", err_cnt);
            end
         end
      end
      total++;
      if ({err_cnt, fifo_count} !== {8'd255, 3'd0}) begin
         bad++;
         $display("FAIL err_saturate err=%0d count=%0d exp 255 0", err_cnt, fifo_count);
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_basic();
      test_integrity();
      test_overflow();
      test_repeat();
      test_disable_and_reset();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog elapsed=1ms limit=1ms");
      $fatal(1, "watchdog");
   end

endmodule
